rs_issue_queue: RTL and testbench
=================================

Name: rs_issue_queue

Overview:
Parametrised reservation station that sits between ROB dispatch and one ALU. It holds up to DEPTH waiting instructions and wakes operands from CDB_N result-broadcast buses, including same-cycle bypass at insertion. It selects the oldest ready entry through an age matrix and feeds a registered issue slot under a valid/ready handshake with the ALU. A flush input empties it in one cycle on exception or mispredict.

Parameters:
DEPTH, 8, number of entries (2..32)
DATA_W, 32, operand/immediate/pc width
OP_W, 6, opcode width
TAG_W, 5, ROB tag width
CDB_N, 2, number of result-broadcast buses

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous clear of all entries and the issue slot
in_valid  in  1  dispatch request
in_ready  out  1  at least one free entry
in_op  in  OP_W  opcode
in_pc  in  DATA_W  instruction pc
in_imm  in  DATA_W  immediate
in_tag  in  TAG_W  destination ROB tag
in_v1, in_v2  in  DATA_W  operand values (meaningful when ready)
in_q1, in_q2  in  TAG_W  producer tags (meaningful when not ready)
in_r1, in_r2  in  1  operand ready flags
cdb_valid  in  CDB_N  broadcast valid, one bit per bus
cdb_tag  in  CDB_N*TAG_W  broadcast tags, bus k at bits [k*TAG_W +: TAG_W]
cdb_data  in  CDB_N*DATA_W  broadcast data, same packing
iss_valid  out  1  issue slot holds an instruction
iss_ready  in  1  ALU accepts this cycle
iss_op, iss_pc, iss_imm, iss_v1, iss_v2, iss_tag  out  —  issue slot contents
count  out  $clog2(DEPTH+1)  occupied entries, issue slot excluded

Behaviour:
- Reset (rst=1) or flush=1: all entry valid bits cleared, age matrix cleared, iss_valid=0, every iss_* data output=0, count=0; in_valid ignored that cycle. rst takes priority over flush; both act at the edge. Reset mid-handshake drops the slot without an ALU transfer.
- in_ready = (count != DEPTH). Decoded from registered state only, so it does not count a same-cycle free. Dispatch accepted when in_valid && in_ready.
- Allocation: lowest-index free entry. The new entry's age row is set to "older than none"; every existing valid entry is marked older than it.
- Insertion bypass: for each operand with r=0, if any cdb_valid[k] && cdb_tag[k]==q, the entry is stored ready with cdb_data[k]. Lowest k wins on duplicate tags.
- Wakeup: each valid entry compares every unready operand against all CDB buses each cycle. On match it latches the data and sets ready at the edge. Both operands may wake in the same cycle from different buses.
- Eligibility uses registered ready bits only. An entry woken in cycle t is selectable in cycle t+1.
- Select: among valid entries with both operands ready, pick the one no other eligible entry is older than (one-hot).
- Issue slot load: when (!iss_valid || iss_ready) and an eligible entry exists, copy it to iss_* and free it at the same edge. Clear its age column.
- Issue slot hold: if iss_valid && !iss_ready, iss_* stays stable and no entry is freed.
- Issue slot drain: if iss_ready with nothing eligible, iss_valid goes to 0.
- Minimum latency: accept at edge t with both operands ready; selected in cycle t+1; iss_valid=1 from edge t+1 onward, i.e. observed in cycle t+2.
- Full boundary: with count==DEPTH and an issue on the same edge, dispatch is still refused that cycle. in_ready rises the next cycle.
- Tag value 0 has no special meaning; readiness is carried only by the r flags.
- Simultaneous dispatch, wakeup, select and flush in one cycle: flush wins, and nothing is retained.

Decomposition:
- Shared package rs_pkg: default widths, CDB bus packing helper functions, opcode width constant shared with the ROB and ALU.
- Sub-module rs_age_matrix (DEPTH x DEPTH bit matrix) owns:
  - inputs: alloc one-hot, free one-hot, request vector
  - output: oldest one-hot grant
- Top level owns the entry storage, wakeup comparators, bypass logic and the issue slot.

Test Plan:
1. Dispatch A (r1=r2=1, v1=5, v2=7, tag=3) at cycle 0, iss_ready=1 -> iss_valid=1 in cycle 2 with iss_v1=5, iss_v2=7, iss_tag=3; count returns to 0.
2. Dispatch B with q1=9 unready, then cdb_valid[1]=1, cdb_tag=9, data=0x55 at cycle 3 -> B issues with iss_v1=0x55, iss_valid rises in cycle 5, not earlier.
3. Dispatch C with q2=4 while cdb bus 0 broadcasts tag 4, data 0xAA, in the same cycle -> C stored ready, issues 2 cycles later with iss_v2=0xAA.
4. Fill 8 entries with iss_ready=0 -> in_ready=0, count=8; pulse iss_ready for 1 cycle -> oldest ready entry (first dispatched) issues, and in_ready returns 1 one cycle later.
5. Dispatch D (unready) then E (ready), then wake D -> E issues first; with both ready, the older one always wins regardless of entry index (allocate into freed index 0 after index 5).
6. Hold iss_valid=1 with iss_ready=0 for 3 cycles, then assert flush -> iss_* stable during the hold; next cycle iss_valid=0, count=0, in_ready=1.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared widths and CDB bus packing helpers for the reservation station,
// the ROB and the ALU.
package rs_pkg;
   localparam int DEPTH_DEF  = 8;
   localparam int DATA_W_DEF = 32;
   localparam int RS_OP_W    = 6;
   localparam int TAG_W_DEF  = 5;
   localparam int CDB_N_DEF  = 2;

   // Bus k sits at bits [k*w +: w] of a packed CDB field.
   function automatic int bus_lsb(input int k, input int w);
      return k * w;
   endfunction
endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix for DEPTH entries. Bit older_q[i][j] means entry i is older
// than entry j. Grants the requester that no other requester is older than.
module rs_age_matrix import rs_pkg::*; #(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic [DEPTH-1:0] alloc_i,
   input  logic [DEPTH-1:0] free_i,
   input  logic [DEPTH-1:0] req_i,
   output logic [DEPTH-1:0] gnt_o
);
   logic [DEPTH-1:0] older_q [DEPTH];
   logic [DEPTH-1:0] older_d [DEPTH];

   // A new entry is younger than every other entry; stale rows of free
   // entries are harmless because they never request and are wiped on reuse.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         older_d[i] = older_q[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (free_i[j])  older_d[i][j] = 1'b0;
            if (alloc_i[j]) older_d[i][j] = (i != j);
         end
         if (alloc_i[i]) older_d[i] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) older_q[i] <= older_d[i];
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         logic blocked;
         blocked = 1'b0;
         for (int j = 0; j < DEPTH; j++) blocked = blocked | (req_i[j] & older_q[j][i]);
         gnt_o[i] = req_i[i] & ~blocked;
      end
   end
endmodule

// File: rtl/rs_issue_queue.sv
// Reservation station in front of one ALU: CDB wakeup with insertion bypass,
// oldest-ready select through the age matrix and a registered issue slot.
module rs_issue_queue import rs_pkg::*; #(
   parameter  int DEPTH  = DEPTH_DEF,
   parameter  int DATA_W = DATA_W_DEF,
   parameter  int OP_W   = RS_OP_W,
   parameter  int TAG_W  = TAG_W_DEF,
   parameter  int CDB_N  = CDB_N_DEF,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [OP_W-1:0]         in_op,
   input  logic [DATA_W-1:0]       in_pc,
   input  logic [DATA_W-1:0]       in_imm,
   input  logic [TAG_W-1:0]        in_tag,
   input  logic [DATA_W-1:0]       in_v1,
   input  logic [DATA_W-1:0]       in_v2,
   input  logic [TAG_W-1:0]        in_q1,
   input  logic [TAG_W-1:0]        in_q2,
   input  logic                    in_r1,
   input  logic                    in_r2,
   input  logic [CDB_N-1:0]        cdb_valid,
   input  logic [CDB_N*TAG_W-1:0]  cdb_tag,
   input  logic [CDB_N*DATA_W-1:0] cdb_data,
   output logic                    iss_valid,
   input  logic                    iss_ready,
   output logic [OP_W-1:0]         iss_op,
   output logic [DATA_W-1:0]       iss_pc,
   output logic [DATA_W-1:0]       iss_imm,
   output logic [DATA_W-1:0]       iss_v1,
   output logic [DATA_W-1:0]       iss_v2,
   output logic [TAG_W-1:0]        iss_tag,
   output logic [CNT_W-1:0]        count
);
   logic [DEPTH-1:0]  valid_q, valid_d, r1_q, r2_q;
   logic [OP_W-1:0]   op_q  [DEPTH];
   logic [DATA_W-1:0] pc_q  [DEPTH], imm_q [DEPTH], v1_q [DEPTH], v2_q [DEPTH];
   logic [TAG_W-1:0]  tag_q [DEPTH], q1_q  [DEPTH], q2_q [DEPTH];

   logic [DEPTH-1:0]  alloc_oh, free_oh, eligible, grant, wk1, wk2;
   logic [DATA_W-1:0] wd1 [DEPTH], wd2 [DEPTH];
   logic              accept, load, b1_hit, b2_hit;
   logic [DATA_W-1:0] b1_data, b2_data;

   logic              iss_valid_q;
   logic [OP_W-1:0]   iss_op_q, sel_op;
   logic [DATA_W-1:0] iss_pc_q, iss_imm_q, iss_v1_q, iss_v2_q;
   logic [DATA_W-1:0] sel_pc, sel_imm, sel_v1, sel_v2;
   logic [TAG_W-1:0]  iss_tag_q, sel_tag;

   always_comb begin
      count = '0;
      for (int i = 0; i < DEPTH; i++) count = count + {{(CNT_W-1){1'b0}}, valid_q[i]};
   end

   assign in_ready = (count != CNT_W'(DEPTH));
   assign accept   = in_valid && in_ready;
   assign eligible = valid_q & r1_q & r2_q;
   assign load     = (!iss_valid_q || iss_ready) && (|eligible);
   assign free_oh  = load ? grant : '0;
   assign valid_d  = (valid_q & ~free_oh) | alloc_oh;

   always_comb begin
      logic found;
      alloc_oh = '0;
      found    = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!valid_q[i] && !found) begin
            alloc_oh[i] = accept;
            found       = 1'b1;
         end
      end
   end

   // Buses are scanned high to low so the lowest matching bus wins.
   always_comb begin
      b1_hit  = 1'b0;
      b2_hit  = 1'b0;
      b1_data = '0;
      b2_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         wk1[i] = 1'b0;
         wk2[i] = 1'b0;
         wd1[i] = '0;
         wd2[i] = '0;
      end
      for (int k = CDB_N - 1; k >= 0; k--) begin
         if (cdb_valid[k]) begin
            if (cdb_tag[bus_lsb(k, TAG_W) +: TAG_W] == in_q1) begin
               b1_hit  = 1'b1;
               b1_data = cdb_data[bus_lsb(k, DATA_W) +: DATA_W];
            end
            if (cdb_tag[bus_lsb(k, TAG_W) +: TAG_W] == in_q2) begin
               b2_hit  = 1'b1;
               b2_data = cdb_data[bus_lsb(k, DATA_W) +: DATA_W];
            end
            for (int i = 0; i < DEPTH; i++) begin
               if (cdb_tag[bus_lsb(k, TAG_W) +: TAG_W] == q1_q[i]) begin
                  wk1[i] = 1'b1;
                  wd1[i] = cdb_data[bus_lsb(k, DATA_W) +: DATA_W];
               end
               if (cdb_tag[bus_lsb(k, TAG_W) +: TAG_W] == q2_q[i]) begin
                  wk2[i] = 1'b1;
                  wd2[i] = cdb_data[bus_lsb(k, DATA_W) +: DATA_W];
               end
            end
         end
      end
   end

   rs_age_matrix #(.DEPTH(DEPTH)) u_age (
      .clk     (clk),
      .rst     (rst),
      .clear_i (flush),
      .alloc_i (alloc_oh),
      .free_i  (free_oh),
      .req_i   (eligible),
      .gnt_o   (grant)
   );

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (alloc_oh[i]) begin
            op_q[i]  <= in_op;
            pc_q[i]  <= in_pc;
            imm_q[i] <= in_imm;
            tag_q[i] <= in_tag;
            q1_q[i]  <= in_q1;
            q2_q[i]  <= in_q2;
            r1_q[i]  <= in_r1 | b1_hit;
            r2_q[i]  <= in_r2 | b2_hit;
            v1_q[i]  <= in_r1 ? in_v1 : b1_data;
            v2_q[i]  <= in_r2 ? in_v2 : b2_data;
         end else begin
            if (!r1_q[i] && wk1[i]) begin
               r1_q[i] <= 1'b1;
               v1_q[i] <= wd1[i];
            end
            if (!r2_q[i] && wk2[i]) begin
               r2_q[i] <= 1'b1;
               v2_q[i] <= wd2[i];
            end
         end
      end
   end

   always_comb begin
      sel_op  = '0;
      sel_pc  = '0;
      sel_imm = '0;
      sel_v1  = '0;
      sel_v2  = '0;
      sel_tag = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (grant[i]) begin
            sel_op  = op_q[i];
            sel_pc  = pc_q[i];
            sel_imm = imm_q[i];
            sel_v1  = v1_q[i];
            sel_v2  = v2_q[i];
            sel_tag = tag_q[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         valid_q     <= '0;
         iss_valid_q <= 1'b0;
         iss_op_q    <= '0;
         iss_pc_q    <= '0;
         iss_imm_q   <= '0;
         iss_v1_q    <= '0;
         iss_v2_q    <= '0;
         iss_tag_q   <= '0;
      end else begin
         valid_q <= valid_d;
         if (load) begin
            iss_valid_q <= 1'b1;
            iss_op_q    <= sel_op;
            iss_pc_q    <= sel_pc;
            iss_imm_q   <= sel_imm;
            iss_v1_q    <= sel_v1;
            iss_v2_q    <= sel_v2;
            iss_tag_q   <= sel_tag;
         end else if (iss_ready) begin
            iss_valid_q <= 1'b0;
         end
      end
   end

   assign iss_valid = iss_valid_q;
   assign iss_op    = iss_op_q;
   assign iss_pc    = iss_pc_q;
   assign iss_imm   = iss_imm_q;
   assign iss_v1    = iss_v1_q;
   assign iss_v2    = iss_v2_q;
   assign iss_tag   = iss_tag_q;
endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed bench for rs_issue_queue: a per-cycle vector table for single
// instructions plus hand-written fill, age-order, hold/flush and reset sequences.
module tb_rs_issue_queue;
   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, in_r1, in_r2;
   logic [5:0]  in_op;
   logic [31:0] in_pc, in_imm, in_v1, in_v2;
   logic [4:0]  in_tag, in_q1, in_q2;
   logic [1:0]  cdb_valid;
   logic [9:0]  cdb_tag;
   logic [63:0] cdb_data;
   logic        iss_valid, iss_ready;
   logic [5:0]  iss_op;
   logic [31:0] iss_pc, iss_imm, iss_v1, iss_v2;
   logic [4:0]  iss_tag;
   logic [3:0]  count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rs_issue_queue dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_pc(in_pc), .in_imm(in_imm), .in_tag(in_tag),
      .in_v1(in_v1), .in_v2(in_v2), .in_q1(in_q1), .in_q2(in_q2),
      .in_r1(in_r1), .in_r2(in_r2),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_op(iss_op), .iss_pc(iss_pc), .iss_imm(iss_imm),
      .iss_v1(iss_v1), .iss_v2(iss_v2), .iss_tag(iss_tag),
      .count(count)
   );

   typedef struct {
      int inv, r1, v1, q1, r2, v2, q2, tag;
      int cv, ct0, cd0, ct1, cd1;
      int e_iv, e_v1, e_v2, e_tag, e_cnt;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(int inv, int r1, int v1, int q1, int r2, int v2, int q2, int tag,
                               int cv, int ct0, int cd0, int ct1, int cd1,
                               int e_iv, int e_v1, int e_v2, int e_tag, int e_cnt);
      vec_t v;
      v.inv = inv; v.r1 = r1; v.v1 = v1; v.q1 = q1; v.r2 = r2; v.v2 = v2; v.q2 = q2; v.tag = tag;
      v.cv = cv; v.ct0 = ct0; v.cd0 = cd0; v.ct1 = ct1; v.cd1 = cd1;
      v.e_iv = e_iv; v.e_v1 = e_v1; v.e_v2 = e_v2; v.e_tag = e_tag; v.e_cnt = e_cnt;
      return v;
   endfunction

   function automatic logic [31:0] op_of(int t);  return 32'((t + 1) % 64);          endfunction
   function automatic logic [31:0] pc_of(int t);  return 32'(32'h1000 + t * 4);       endfunction
   function automatic logic [31:0] imm_of(int t); return 32'(t) ^ 32'hA5A5_0000;       endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(int inv, int r1, int v1, int q1, int r2, int v2, int q2, int tag);
      in_valid = inv[0];
      in_r1 = r1[0];  in_v1 = 32'(v1); in_q1 = 5'(q1);
      in_r2 = r2[0];  in_v2 = 32'(v2); in_q2 = 5'(q2);
      in_tag = 5'(tag);
      in_op  = 6'(op_of(tag));
      in_pc  = pc_of(tag);
      in_imm = imm_of(tag);
   endtask

   task automatic set_cdb(int cv, int ct0, int cd0, int ct1, int cd1);
      cdb_valid = 2'(cv);
      cdb_tag   = {5'(ct1), 5'(ct0)};
      cdb_data  = {32'(cd1), 32'(cd0)};
   endtask

   task automatic idle;
      flush = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      set_cdb(0, 0, 0, 0, 0);
   endtask

   task automatic chk_occ(input string name, int cnt);
      chk({name, " count"}, 32'(count), 32'(cnt));
      chk({name, " in_ready"}, 32'(in_ready), (cnt != 8) ? 32'd1 : 32'd0);
   endtask

   task automatic chk_slot(input string name, int tag, int v1, int v2);
      chk({name, " iss_valid"}, 32'(iss_valid), 32'd1);
      chk({name, " iss_tag"}, 32'(iss_tag), 32'(tag));
      chk({name, " iss_v1"}, iss_v1, 32'(v1));
      chk({name, " iss_v2"}, iss_v2, 32'(v2));
      chk({name, " iss_op"}, 32'(iss_op), op_of(tag));
      chk({name, " iss_pc"}, iss_pc, pc_of(tag));
      chk({name, " iss_imm"}, iss_imm, imm_of(tag));
   endtask

   initial begin
      // single-instruction scenarios, one row per cycle
      vt.push_back(mk(1,1,5,0,1,7,0,3,        0,0,0,0,0,         0,0,0,0,1));
      vt.push_back(mk(0,0,0,0,0,0,0,0,        0,0,0,0,0,         1,5,7,3,0));
      vt.push_back(mk(0,0,0,0,0,0,0,0,        0,0,0,0,0,         0,0,0,0,0));
      vt.push_back(mk(1,0,0,9,1,2,0,6,        0,0,0,0,0,         0,0,0,0,1));
      vt.push_back(mk(0,0,0,0,0,0,0,0,        1,8,'h99,0,0,      0,0,0,0,1));
      vt.push_back(mk(0,0,0,0,0,0,0,0,        0,0,0,0,0,         0,0,0,0,1));
      vt.push_back(mk(0,0,0,0,0,0,0,0,        2,9,'h11,9,'h55,   0,0,0,0,1));
      vt.push_back(mk(0,0,0,0,0,0,0,0,        0,0,0,0,0,         1,'h55,2,6,0));
      vt.push_back(mk(0,0,0,0,0,0,0,0,        0,0,0,0,0,         0,0,0,0,0));
      vt.push_back(mk(1,1,1,0,0,0,4,7,        3,4,'hAA,4,'hBB,   0,0,0,0,1));
      vt.push_back(mk(0,0,0,0,0,0,0,0,        0,0,0,0,0,         1,1,'hAA,7,0));
      vt.push_back(mk(0,0,0,0,0,0,0,0,        0,0,0,0,0,         0,0,0,0,0));
      vt.push_back(mk(1,1,'h10,0,1,'h20,0,1,  1,0,'hEE,0,0,      0,0,0,0,1));
      vt.push_back(mk(0,0,0,0,0,0,0,0,        0,0,0,0,0,         1,'h10,'h20,1,0));
      vt.push_back(mk(0,0,0,0,0,0,0,0,        0,0,0,0,0,         0,0,0,0,0));
      vt.push_back(mk(1,0,0,0,1,'h21,0,2,     0,0,0,0,0,         0,0,0,0,1));
      vt.push_back(mk(0,0,0,0,0,0,0,0,        2,5,'h44,0,'h33,   0,0,0,0,1));
      vt.push_back(mk(0,0,0,0,0,0,0,0,        0,0,0,0,0,         1,'h33,'h21,2,0));
      vt.push_back(mk(0,0,0,0,0,0,0,0,        0,0,0,0,0,         0,0,0,0,0));

      rst = 1'b1;
      iss_ready = 1'b1;
      idle();
      tick();
      tick();
      chk("reset iss_valid", 32'(iss_valid), 32'd0);
      chk_occ("reset", 0);
      chk("reset iss_tag", 32'(iss_tag), 32'd0);
      chk("reset iss_v1", iss_v1, 32'd0);
      chk("reset iss_op", 32'(iss_op), 32'd0);
      rst = 1'b0;

      foreach (vt[i]) begin
         set_in(vt[i].inv, vt[i].r1, vt[i].v1, vt[i].q1, vt[i].r2, vt[i].v2, vt[i].q2, vt[i].tag);
         set_cdb(vt[i].cv, vt[i].ct0, vt[i].cd0, vt[i].ct1, vt[i].cd1);
         tick();
         chk_occ($sformatf("vec%0d", i), vt[i].e_cnt);
         if (vt[i].e_iv != 0) chk_slot($sformatf("vec%0d", i), vt[i].e_tag, vt[i].e_v1, vt[i].e_v2);
         else chk($sformatf("vec%0d iss_valid", i), 32'(iss_valid), 32'd0);
      end
      idle();

      // fill: first entry lands in the empty slot, eight more fill the station
      iss_ready = 1'b0;
      for (int k = 0; k < 9; k++) begin
         set_in(1, 1, 'h100 + k, 0, 1, 'h200 + k, 0, 10 + k);
         tick();
      end
      chk_occ("full", 8);
      chk_slot("full", 10, 'h100, 'h200);
      set_in(1, 1, 'h109, 0, 1, 'h209, 0, 19);
      tick();
      chk_occ("full refused", 8);
      chk_slot("full refused", 10, 'h100, 'h200);
      iss_ready = 1'b1;
      tick();
      chk_occ("full issue", 7);
      chk_slot("full issue", 11, 'h101, 'h201);
      iss_ready = 1'b0;
      tick();
      chk_occ("refill", 8);
      chk_slot("refill hold", 11, 'h101, 'h201);
      idle();
      iss_ready = 1'b1;
      for (int n = 0; n < 8; n++) begin
         int t;
         t = (n < 7) ? 12 + n : 19;
         tick();
         chk_occ($sformatf("age drain%0d", n), 7 - n);
         chk_slot($sformatf("age drain%0d", n), t, 'h100 + t - 10, 'h200 + t - 10);
      end
      tick();
      chk("age drained iss_valid", 32'(iss_valid), 32'd0);

      // younger ready entry overtakes an older waiting one
      set_in(1, 0, 0, 12, 1, 'h31, 0, 21);
      tick();
      set_in(1, 1, 'h40, 0, 1, 'h41, 0, 22);
      tick();
      chk_occ("de loaded", 2);
      idle();
      set_cdb(1, 12, 'h77, 0, 0);
      tick();
      chk_occ("de first", 1);
      chk_slot("de first", 22, 'h40, 'h41);
      idle();
      tick();
      chk_occ("de second", 0);
      chk_slot("de second", 21, 'h77, 'h31);
      tick();
      chk("de drained iss_valid", 32'(iss_valid), 32'd0);

      // hold for three cycles, then flush alongside every other activity
      iss_ready = 1'b0;
      set_in(1, 1, 'h250, 0, 1, 'h251, 0, 25);
      tick();
      set_in(1, 0, 0, 3, 1, 'h261, 0, 26);
      tick();
      idle();
      for (int h = 0; h < 3; h++) begin
         set_cdb(1, 3, 'h5A, 0, 0);
         tick();
         chk_occ($sformatf("hold%0d", h), 1);
         chk_slot($sformatf("hold%0d", h), 25, 'h250, 'h251);
      end
      set_in(1, 1, 1, 0, 1, 2, 0, 27);
      set_cdb(3, 1, 'h1, 2, 'h2);
      iss_ready = 1'b1;
      flush = 1'b1;
      tick();
      chk("flush iss_valid", 32'(iss_valid), 32'd0);
      chk("flush iss_tag", 32'(iss_tag), 32'd0);
      chk("flush iss_v1", iss_v1, 32'd0);
      chk_occ("flush", 0);
      idle();
      tick();
      tick();
      chk("post flush iss_valid", 32'(iss_valid), 32'd0);
      chk_occ("post flush", 0);

      // reset while the slot is held drops it without a transfer
      iss_ready = 1'b0;
      set_in(1, 1, 'h70, 0, 1, 'h71, 0, 30);
      tick();
      idle();
      tick();
      chk_slot("pre reset", 30, 'h70, 'h71);
      rst = 1'b1;
      flush = 1'b1;
      tick();
      rst = 1'b0;
      flush = 1'b0;
      chk("mid reset iss_valid", 32'(iss_valid), 32'd0);
      chk("mid reset iss_pc", iss_pc, 32'd0);
      chk_occ("mid reset", 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
